// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring divider: one quotient bit per clock, start/ready in, done pulse out.
// Optional two's-complement operands when DIVIDER_SIGNED_EN is defined.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// ITER  | one shift/add-or-subtract step per edge, WIDTH steps
// CORR  | final remainder correction and result load (skipped for divide-by-zero)
// DONE  | done pulse visible, back to IDLE on next edge
module nonrestoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;

  logic [WIDTH:0]   d_ext, p_sh, p_step, p_fix;
  logic [WIDTH-1:0] a_cap, b_cap, q_res, r_res;

  assign ready  = (state == IDLE);
  assign d_ext  = {1'b0, d};
  assign p_sh   = {p[WIDTH-1:0], q[WIDTH-1]};
  // Subtract is the inverted divisor with carry-in 1; carry out of the MSB falls off.
  assign p_step = p[WIDTH] ? (p_sh + d_ext) : (p_sh + ~d_ext + {{WIDTH{1'b0}}, 1'b1});
  assign p_fix  = p[WIDTH] ? (p + d_ext) : p;

`ifdef DIVIDER_SIGNED_EN
  logic q_neg, r_neg;

  assign a_cap = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_cap = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign q_res = q_neg ? (~q + 1'b1) : q;
  assign r_res = r_neg ? (~p_fix[WIDTH-1:0] + 1'b1) : p_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && start) begin
      q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg <= dividend[WIDTH-1];
    end
  end
`else
  assign a_cap = dividend;
  assign b_cap = divisor;
  assign q_res = q;
  assign r_res = p_fix[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      count     <= '0;
      p         <= '0;
      q         <= '0;
      d         <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // Results land now; CORR only spends the cycle so done appears one edge later.
              quotient  <= '1;
              remainder <= dividend;
              dbz       <= 1'b1;
              state     <= CORR;
            end else begin
              p     <= '0;
              q     <= a_cap;
              d     <= b_cap;
              count <= '0;
              dbz   <= 1'b0;
              state <= ITER;
            end
          end
        end
        ITER: begin
          p     <= p_step;
          q     <= {q[WIDTH-2:0], ~p_step[WIDTH]};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= CORR;
        end
        CORR: begin
          if (!dbz) begin
            quotient  <= q_res;
            remainder <= r_res;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
